ahb_wait_state_memory_slave: RTL
================================

AHB_WAIT_STATE_MEMORY_SLAVE -- requirements
Module: ahb_wait_state_memory_slave

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, width of HADDR.
REQ-002 Parameter DATA_WIDTH, default 32, HWDATA/HRDATA width; legal values 32, 64.
REQ-003 Parameter MEM_DEPTH, default 1024, number of DATA_WIDTH words held.
REQ-004 Parameter BASE_ADDR, default 0, byte address of word 0; aligned to MEM_DEPTH*DATA_WIDTH/8.
REQ-005 Parameter READ_WAIT, default 0, wait states (0..15) inserted on every read data phase.
REQ-006 Parameter WRITE_WAIT, default 0, wait states (0..15) inserted on every write data phase.
REQ-007 HCLK  in  1  clock; all state updates on rising edge.
REQ-008 HRESET  in  1  synchronous active-high reset.
REQ-009 HSEL  in  1  slave select from decoder.
REQ-010 HADDR  in  ADDRESS_WIDTH  byte address, address phase.
REQ-011 HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-012 HWRITE  in  1  1=write.
REQ-013 HSIZE  in  3  transfer size, bytes = 2^HSIZE.
REQ-014 HWDATA  in  DATA_WIDTH  write data, data phase.
REQ-015 HREADY  in  1  bus-level ready (combined).
REQ-016 HREADYOUT  out  1  this slave's ready.
REQ-017 HRESP  out  1  0=OKAY, 1=ERROR.
REQ-018 HRDATA  out  DATA_WIDTH  read data, valid when HREADYOUT=1 and HRESP=0 in a read data phase.

Function
REQ-019 A transfer SHALL be accepted on a rising edge where HSEL=1, HREADY=1, HTRANS[1]=1; address, HWRITE, HSIZE captured there.
REQ-020 IDLE, BUSY or HSEL=0 with HREADY=1 SHALL leave the slave in IDLE with HREADYOUT=1, HRESP=0 next cycle.
REQ-021 States: IDLE, WAIT, LAST, ERR1, ERR2.
REQ-022 Accepted legal transfer with N wait states (READ_WAIT or WRITE_WAIT) SHALL enter WAIT for N cycles (HREADYOUT=0, HRESP=0), then LAST for one cycle (HREADYOUT=1, HRESP=0); N=0 goes directly to LAST.
REQ-023 A transfer accepted while in LAST (pipelined, HREADY=1) SHALL start its own data phase the next cycle with no bubble.
REQ-024 Illegal transfer = address outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*DATA_WIDTH/8), or 2^HSIZE > DATA_WIDTH/8, or HADDR not aligned to 2^HSIZE.
REQ-025 Illegal transfer SHALL go ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), ignoring wait parameters; memory never modified.
REQ-026 In ERR2 a newly offered transfer SHALL be accepted exactly as in LAST.
REQ-027 Writes SHALL commit on the LAST-state edge, updating only the byte lanes selected by HSIZE and HADDR low bits (little-endian); other bytes unchanged.
REQ-028 Reads SHALL drive the full addressed word on HRDATA in LAST; HRDATA=0 in all other states.
REQ-029 A read accepted on the same edge a write to the same word commits SHALL return the post-write value (write-to-read forwarding).
REQ-030 Word index = (HADDR - BASE_ADDR) >> log2(DATA_WIDTH/8), width clog2(MEM_DEPTH).
REQ-031 Wait counter SHALL be 4 bits, load N-1 on entry to WAIT, decrement to 0, then exit to LAST.

Reset
REQ-032 HRESET=1 on a rising edge SHALL force state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0.
REQ-033 Reset during WAIT/LAST/ERR1/ERR2 SHALL abort the transfer; a write in progress SHALL NOT commit.
REQ-034 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-035 Defaults: NONSEQ write 0x0000_0010 data 0xDEAD_BEEF, then read 0x10 -> both zero-wait, read returns 0xDEAD_BEEF, HRESP=0 throughout.
REQ-036 READ_WAIT=3: read 0x10 -> HREADYOUT low exactly 3 cycles, high on 4th with data; pipelined next read starts next cycle.
REQ-037 Byte write HSIZE=0 to 0x13 data 0xAA00_0000 over word 0x1122_3344 -> read returns 0xAA22_3344.
REQ-038 Read at BASE_ADDR+MEM_DEPTH*4 (0x1000) and halfword at 0x11 -> each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (1,1); memory unchanged.
REQ-039 Write 0x5555_5555 to 0x20 immediately followed by read 0x20 -> read returns 0x5555_5555 (forwarding).
REQ-040 WRITE_WAIT=4, assert HRESET in 2nd wait cycle of write 0x30 -> next cycle HREADYOUT=1, HRESP=0; later read 0x30 returns pre-write value.

Source files
------------

// File: rtl/ahb_wait_state_memory_slave.sv
// -----------------------------------------------------------------------------
// ahb_wait_state_memory_slave
//
// AHB-Lite memory slave. It holds MEM_DEPTH words of DATA_WIDTH bits and adds
// a fixed number of wait states to each read or write data phase. Transfers
// that fall outside the memory window, that are wider than the bus, or that
// are not aligned get the two-cycle ERROR response and never touch memory.
//
// Parameters
//   ADDRESS_WIDTH  width of HADDR
//   DATA_WIDTH     width of HWDATA/HRDATA (32 or 64)
//   MEM_DEPTH      number of DATA_WIDTH words (power of two, >= 2)
//   BASE_ADDR      byte address of word 0, aligned to the memory size
//   READ_WAIT      wait states on every read data phase (0..15)
//   WRITE_WAIT     wait states on every write data phase (0..15)
//
// Ports
//   HCLK       in   clock, all state changes on the rising edge
//   HRESET     in   synchronous active-high reset
//   HSEL       in   slave select from the address decoder
//   HADDR      in   byte address (address phase)
//   HTRANS     in   IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   HWRITE     in   1 = write
//   HSIZE      in   transfer size, bytes = 2^HSIZE
//   HWDATA     in   write data (data phase)
//   HREADY     in   combined bus ready
//   HREADYOUT  out  this slave's ready
//   HRESP      out  0 = OKAY, 1 = ERROR
//   HRDATA     out  read data, valid in the last cycle of a read data phase
// -----------------------------------------------------------------------------
module ahb_wait_state_memory_slave #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       MEM_DEPTH     = 1024,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                       READ_WAIT     = 0,
    parameter int                       WRITE_WAIT    = 0
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     HSEL,
    input  logic [ADDRESS_WIDTH-1:0] HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [DATA_WIDTH-1:0]    HWDATA,
    input  logic                     HREADY,
    output logic                     HREADYOUT,
    output logic                     HRESP,
    output logic [DATA_WIDTH-1:0]    HRDATA
);

    localparam int NB = DATA_WIDTH / 8;           // bytes per word
    localparam int LB = $clog2(NB);               // byte-lane address bits
    localparam int IW = $clog2(MEM_DEPTH);        // word index bits

    localparam logic [ADDRESS_WIDTH:0] MEM_BYTES = (ADDRESS_WIDTH + 1)'(MEM_DEPTH * NB);
    localparam logic [3:0]             RD_WAIT   = 4'(READ_WAIT);
    localparam logic [3:0]             WR_WAIT   = 4'(WRITE_WAIT);

    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LAST = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Replace the byte lanes flagged in lane_en with the matching bytes of new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         lane_en
    );
        logic [DATA_WIDTH-1:0] result;
        for (int b = 0; b < NB; b++) begin
            if (lane_en[b]) begin
                result[b*8 +: 8] = new_word[b*8 +: 8];
            end else begin
                result[b*8 +: 8] = old_word[b*8 +: 8];
            end
        end
        return result;
    endfunction

    // Storage and registered state
    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];
    state_t                state_r;
    logic [3:0]            wait_cnt_r;
    logic                  write_r;
    logic [IW-1:0]         idx_r;
    logic [NB-1:0]         be_r;
    logic                  hreadyout_r;
    logic                  hresp_r;
    logic [DATA_WIDTH-1:0] hrdata_r;

    // Address-phase decode
    logic [ADDRESS_WIDTH-1:0] offset_s;
    logic [LB-1:0]            lane_s;
    logic [LB-1:0]            size_mask_s;
    logic [IW-1:0]            idx_s;
    logic [NB-1:0]            be_s;
    logic                     in_range_s;
    logic                     size_ok_s;
    logic                     aligned_s;
    logic                     legal_s;
    logic                     can_accept_s;
    logic                     accept_s;
    logic [3:0]               wait_n_s;

    // Data-path helpers
    logic                  commit_s;
    logic [DATA_WIDTH-1:0] wr_word_s;
    logic [IW-1:0]         rd_idx_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    // Decode the offered transfer: window, size and alignment checks, byte lanes.
    always_comb begin
        offset_s   = HADDR - BASE_ADDR;
        lane_s     = offset_s[LB-1:0];
        idx_s      = offset_s[LB +: IW];
        in_range_s = (HADDR >= BASE_ADDR) && ({1'b0, offset_s} < MEM_BYTES);
        size_ok_s  = (HSIZE <= 3'(LB));
        // Low address bits that must be zero for a transfer of this size.
        for (int b = 0; b < LB; b++) begin
            size_mask_s[b] = (HSIZE > 3'(b));
        end
        aligned_s = ((lane_s & size_mask_s) == '0);
        // A byte lane is written when it lies in the same size-aligned block as the address.
        for (int b = 0; b < NB; b++) begin
            be_s[b] = ((LB'(b) & ~size_mask_s) == (lane_s & ~size_mask_s));
        end
        legal_s      = in_range_s && size_ok_s && aligned_s;
        can_accept_s = (state_r == ST_IDLE) || (state_r == ST_LAST) || (state_r == ST_ERR2);
        accept_s     = HSEL && HREADY && can_accept_s &&
                       ((HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ));
        if (HWRITE) begin
            wait_n_s = WR_WAIT;
        end else begin
            wait_n_s = RD_WAIT;
        end
    end

    // Write commit and read-word selection, with forwarding of a same-edge write.
    always_comb begin
        commit_s  = (state_r == ST_LAST) && write_r && !HRESET;
        wr_word_s = merge_bytes(mem_r[idx_r], HWDATA, be_r);
        // A read leaving WAIT uses its captured index; a read accepted now uses the live one.
        if (state_r == ST_WAIT) begin
            rd_idx_s = idx_r;
        end else begin
            rd_idx_s = idx_s;
        end
        if (commit_s && (idx_r == rd_idx_s)) begin
            rd_word_s = wr_word_s;
        end else begin
            rd_word_s = mem_r[rd_idx_s];
        end
    end

    // Memory write port; no reset so contents survive HRESET.
    always_ff @(posedge HCLK) begin
        if (commit_s) begin
            mem_r[idx_r] <= wr_word_s;
        end
    end

    // Transfer FSM with registered HREADYOUT/HRESP/HRDATA and address-phase capture.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 4'd0;
            write_r     <= 1'b0;
            idx_r       <= '0;
            be_r        <= '0;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
            hrdata_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_LAST, ST_ERR2: begin
                    if (accept_s) begin
                        if (!legal_s) begin
                            state_r     <= ST_ERR1;
                            write_r     <= 1'b0;
                            hreadyout_r <= 1'b0;
                            hresp_r     <= 1'b1;
                            hrdata_r    <= '0;
                        end else if (wait_n_s == 4'd0) begin
                            state_r     <= ST_LAST;
                            write_r     <= HWRITE;
                            idx_r       <= idx_s;
                            be_r        <= be_s;
                            hreadyout_r <= 1'b1;
                            hresp_r     <= 1'b0;
                            if (HWRITE) begin
                                hrdata_r <= '0;
                            end else begin
                                hrdata_r <= rd_word_s;
                            end
                        end else begin
                            state_r     <= ST_WAIT;
                            wait_cnt_r  <= wait_n_s - 4'd1;
                            write_r     <= HWRITE;
                            idx_r       <= idx_s;
                            be_r        <= be_s;
                            hreadyout_r <= 1'b0;
                            hresp_r     <= 1'b0;
                            hrdata_r    <= '0;
                        end
                    end else begin
                        state_r     <= ST_IDLE;
                        write_r     <= 1'b0;
                        hreadyout_r <= 1'b1;
                        hresp_r     <= 1'b0;
                        hrdata_r    <= '0;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == 4'd0) begin
                        state_r     <= ST_LAST;
                        hreadyout_r <= 1'b1;
                        hresp_r     <= 1'b0;
                        if (write_r) begin
                            hrdata_r <= '0;
                        end else begin
                            hrdata_r <= rd_word_s;
                        end
                    end else begin
                        wait_cnt_r  <= wait_cnt_r - 4'd1;
                        hreadyout_r <= 1'b0;
                        hresp_r     <= 1'b0;
                        hrdata_r    <= '0;
                    end
                end
                ST_ERR1: begin
                    state_r     <= ST_ERR2;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= 1'b1;
                    hrdata_r    <= '0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    wait_cnt_r  <= 4'd0;
                    write_r     <= 1'b0;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= 1'b0;
                    hrdata_r    <= '0;
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;
    assign HRDATA    = hrdata_r;

endmodule
